boolean2a: RTL and testbench

BOOLEAN2A -- requirements
Module: boolean2a

---
 rtl/boolean2a.sv | 74 +++++++
 tb/tb_boolean2a.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/boolean2a.sv
// Three-input Boolean lookup with configurable input synchronization, registered
// result and index, a pipeline-fill valid flag and a saturating toggle counter.
module boolean2a #(
    parameter logic [7:0] TRUTH_TABLE = 8'hCA,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    output logic        d,
    output logic        d_valid,
    output logic [2:0]  idx,
    output logic [15:0] toggle_cnt
);

    localparam logic [1:0] FILL_LAST = SYNC_STAGES[1:0];

    logic [2:0] sync_idx;
    logic       d_next;
    logic [1:0] fill_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    // Stage p0: input synchronizer; all three bits move together so an index is used whole
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_idx = {a, b, c};
        end else begin : g_sync
            logic [2:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b000;
                end else begin
                    sync_q[0] <= {a, b, c};
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end

            assign sync_idx = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign d_next = TRUTH_TABLE[sync_idx];

    // Stage p1: result register, index tag and toggle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d          <= 1'b0;
            idx        <= 3'b000;
            toggle_cnt <= 16'h0000;
        end else begin
            d   <= d_next;
            idx <= sync_idx;
            if (d_next != d) toggle_cnt <= sat_inc(toggle_cnt);
        end
    end

    // d_valid rises once every synchronizer stage and the result flop hold post-reset samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt <= 2'd0;
            d_valid  <= 1'b0;
        end else if (!d_valid) begin
            if (fill_cnt == FILL_LAST) d_valid <= 1'b1;
            else                       fill_cnt <= fill_cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_boolean2a.sv
// Bench for boolean2a: default mux table with two sync stages, plus an odd-parity
// instance with no synchronizer, both compared against a behavioural model.
module tb_boolean2a;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a = 1'b0, b = 1'b0, c = 1'b0;
    logic        d1, d_valid1, d2, d_valid2;
    logic [2:0]  idx1, idx2;
    logic [15:0] toggle_cnt1, toggle_cnt2;

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    logic [2:0] hist[$];
    int         edges;
    logic       exp_d1, exp_d2;
    logic [2:0] exp_idx1, exp_idx2;
    int         exp_cnt1, exp_cnt2;
    logic [7:0] mux_tbl = 8'b1100_1010;

    boolean2a #(.TRUTH_TABLE(8'hCA), .SYNC_STAGES(2)) dut_mux (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .d(d1), .d_valid(d_valid1), .idx(idx1), .toggle_cnt(toggle_cnt1)
    );

    boolean2a #(.TRUTH_TABLE(8'h96), .SYNC_STAGES(0)) dut_par (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .d(d2), .d_valid(d_valid2), .idx(idx2), .toggle_cnt(toggle_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        edges    = 0;
        exp_d1   = 1'b0;
        exp_d2   = 1'b0;
        exp_idx1 = 3'b000;
        exp_idx2 = 3'b000;
        exp_cnt1 = 0;
        exp_cnt2 = 0;
    endtask

    // d after an edge is the function of the input seen (stages) edges earlier
    task automatic model_edge();
        logic [2:0] ix1, ix2;
        logic       nd1, nd2;
        if (rst) return;
        hist.push_front({a, b, c});
        if (hist.size() > 4) void'(hist.pop_back());
        edges++;
        ix1 = (hist.size() > 2) ? hist[2] : 3'b000;
        ix2 = hist[0];
        nd1 = ix1[2] ? ix1[1] : ix1[0];
        nd2 = ix2[2] ^ ix2[1] ^ ix2[0];
        if (nd1 != exp_d1 && exp_cnt1 < 65535) exp_cnt1++;
        if (nd2 != exp_d2 && exp_cnt2 < 65535) exp_cnt2++;
        exp_d1 = nd1;   exp_idx1 = ix1;
        exp_d2 = nd2;   exp_idx2 = ix2;
    endtask

    task automatic check_all();
        chk("d_mux",        {15'd0, d1},        {15'd0, exp_d1});
        chk("idx_mux",      {13'd0, idx1},      {13'd0, exp_idx1});
        chk("valid_mux",    {15'd0, d_valid1},  {15'd0, logic'(edges >= 3)});
        chk("toggles_mux",  toggle_cnt1,        exp_cnt1[15:0]);
        chk("d_par",        {15'd0, d2},        {15'd0, exp_d2});
        chk("idx_par",      {13'd0, idx2},      {13'd0, exp_idx2});
        chk("valid_par",    {15'd0, d_valid2},  {15'd0, logic'(edges >= 1)});
        chk("toggles_par",  toggle_cnt2,        exp_cnt2[15:0]);
    endtask

    task automatic cycle(input bit do_chk);
        @(posedge clk);
        model_edge();
        #1;
        if (do_chk) check_all();
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #2 check_all();
        cycle(1);
        cycle(1);
        rst = 1'b0;
        cycle(1);
        chk("valid_edge1_mux", {15'd0, d_valid1}, 16'd0);
        cycle(1);
        cycle(1);
        chk("valid_edge3_mux", {15'd0, d_valid1}, 16'd1);

        // exhaustive sweep: c every 10 cycles, b every 20, a every 40
        for (int i = 0; i < 80; i++) begin
            {a, b, c} = 3'(i / 10);
            cycle(1);
            if (i % 10 == 5)
                chk($sformatf("sweep_idx%0d", i / 10), {15'd0, d1}, {15'd0, mux_tbl[i / 10]});
        end
        for (int i = 0; i < 3; i++) cycle(1);
        chk("sweep_toggle_total", toggle_cnt1, 16'd5);

        // latency: 000 -> 001 shows on the third edge
        {a, b, c} = 3'b000;
        for (int i = 0; i < 4; i++) cycle(1);
        c = 1'b1;
        cycle(1);
        chk("lat_edge1_d", {15'd0, d1}, 16'd0);
        chk("lat_edge1_par", {15'd0, d2}, 16'd1);
        cycle(1);
        chk("lat_edge2_d", {15'd0, d1}, 16'd0);
        cycle(1);
        chk("lat_edge3_d", {15'd0, d1}, 16'd1);
        chk("lat_edge3_idx", {13'd0, idx1}, 16'd1);

        for (int i = 0; i < 200; i++) begin
            {a, b, c} = 3'($urandom_range(0, 7));
            cycle(1);
        end

        // saturation: d follows c, toggled every cycle
        a = 1'b0;
        b = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            c = ~c;
            cycle(0);
        end
        check_all();
        chk("sat_mux", toggle_cnt1, 16'hFFFF);
        chk("sat_par", toggle_cnt2, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            c = ~c;
            cycle(1);
        end

        // asynchronous reset mid-run while d=1
        c = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1);
        chk("pre_rst_d", {15'd0, d1}, 16'd1);
        #3 rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_d", {15'd0, d1}, 16'd0);
        chk("async_rst_cnt", toggle_cnt1, 16'd0);
        chk("async_rst_valid", {15'd0, d_valid1}, 16'd0);
        check_all();
        cycle(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1);
        for (int i = 0; i < 30; i++) begin
            {a, b, c} = 3'($urandom_range(0, 7));
            cycle(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
